// File: rtl/fsm_seq.sv
// Multi-cycle instruction sequencer: owns the program counter, fetches from a
// one-cycle-latency program memory, and decodes each instruction into
// register-file and ALU controls over a FETCH / LATCH / EXEC cycle.
module fsm_seq #(
  parameter int RA_W = 2,
  parameter int PC_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3+2*RA_W:0]   instr,
  input  logic                zero,
  output logic [PC_W-1:0]     pc,
  output logic [3:0]          ALU,
  output logic [RA_W-1:0]     Rd_addr1,
  output logic [RA_W-1:0]     Rd_addr2,
  output logic [RA_W-1:0]     wrt_addr,
  output logic                wrt_en,
  output logic                load_data,
  output logic                busy,
  output logic                halted,
  output logic                err
);

  localparam int IW = 4 + 2*RA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_SET   = 4'b0001,
    OP_INC   = 4'b0010,
    OP_DEC   = 4'b0011,
    OP_LOAD  = 4'b0100,
    OP_STORE = 4'b0101,
    OP_ADD   = 4'b0110,
    OP_COPY  = 4'b0111,
    OP_JMP   = 4'b1000,
    OP_JZ    = 4'b1001,
    OP_HALT  = 4'b1010
  } op_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     ir, ir_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              err_nxt;

  logic [3:0]        op;
  logic [RA_W-1:0]   opr1;
  logic [RA_W-1:0]   opr2;
  logic [PC_W-1:0]   target;

  assign op     = ir[IW-1:IW-4];
  assign opr1   = ir[2*RA_W-1:RA_W];
  assign opr2   = ir[RA_W-1:0];
  assign target = ir[PC_W-1:0];

  // State, instruction register, program counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
      pc    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      pc    <= pc_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state sequencing, pc update and EXEC-only decode of the held instruction
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    pc_nxt    = pc;
    err_nxt   = err;
    ALU       = 4'b0000;
    Rd_addr1  = '0;
    Rd_addr2  = '0;
    wrt_addr  = '0;
    wrt_en    = 1'b0;
    load_data = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          err_nxt   = 1'b0;
        end
      end

      S_FETCH: begin
        busy      = 1'b1;
        state_nxt = S_LATCH;
      end

      S_LATCH: begin
        busy      = 1'b1;
        ir_nxt    = instr;
        state_nxt = S_EXEC;
      end

      S_EXEC: begin
        busy      = 1'b1;
        state_nxt = S_FETCH;
        pc_nxt    = pc + 1'b1;
        case (op)
          OP_NOOP: begin
            ALU = op;
          end
          OP_SET: begin
            ALU      = op;
            wrt_addr = opr1;
            wrt_en   = 1'b1;
          end
          OP_INC, OP_DEC: begin
            ALU      = op;
            Rd_addr1 = opr1;
            wrt_addr = opr1;
            wrt_en   = 1'b1;
          end
          OP_LOAD: begin
            ALU       = op;
            wrt_addr  = opr1;
            wrt_en    = 1'b1;
            load_data = 1'b1;
          end
          OP_STORE: begin
            ALU      = op;
            Rd_addr1 = opr1;
          end
          OP_ADD: begin
            ALU      = op;
            Rd_addr1 = opr1;
            Rd_addr2 = opr2;
            wrt_addr = opr1;
            wrt_en   = 1'b1;
          end
          OP_COPY: begin
            ALU      = op;
            Rd_addr1 = opr2;
            wrt_addr = opr1;
            wrt_en   = 1'b1;
          end
          OP_JMP: begin
            pc_nxt = target;
          end
          OP_JZ: begin
            if (zero) begin
              pc_nxt = target;
            end
          end
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = S_HALT;
          end
          default: begin
            err_nxt = 1'b1;
          end
        endcase
      end

      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          err_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
